register_file_sb: RTL and testbench

Parametrised successor to the 8-entry register file.
- Configurable data width and depth, two combinational read ports and one write port.
- Synchronous reset clears every register.
- Same-cycle write-to-read forwarding.
- Per-register busy scoreboard, set at instruction issue and cleared at writeback, so the control unit can stall on RAW hazards.
- Sits between decode (read/issue) and writeback in the CPU datapath.

---
 rtl/register_file_sb_if.sv | 30 +++
 rtl/register_file_sb.sv | 57 +++++
 tb/tb_register_file_sb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
interface register_file_sb_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             iss_ready;
  logic             busy1;
  logic             busy2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_en, iss_addr,
    input  rd_data1, rd_data2, iss_ready, busy1, busy2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, iss_en, iss_addr,
    output rd_data1, rd_data2, iss_ready, busy1, busy2
  );
endinterface

// File: rtl/register_file_sb.sv
// 2R/1W register file with write-to-read forwarding and a per-register busy scoreboard.
// Optional RF_ZERO_REG_EN: register 0 reads as zero and is never marked busy.
module register_file_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  register_file_sb_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            busy_q, busy_d;

  logic wr_eff, iss_eff, fwd1, fwd2, fwd_iss;

`ifdef RF_ZERO_REG_EN
  // Address 0 is a sink: no storage update, no forwarding, no busy tracking.
  assign wr_eff  = bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_eff = bus.iss_en && bus.iss_ready && (bus.iss_addr != '0);
`else
  assign wr_eff  = bus.wr_en;
  assign iss_eff = bus.iss_en && bus.iss_ready;
`endif

  assign fwd1    = wr_eff && (bus.wr_addr == bus.rd_addr1);
  assign fwd2    = wr_eff && (bus.wr_addr == bus.rd_addr2);
  assign fwd_iss = wr_eff && (bus.wr_addr == bus.iss_addr);

  assign bus.rd_data1  = fwd1 ? bus.wr_data : mem_q[bus.rd_addr1];
  assign bus.rd_data2  = fwd2 ? bus.wr_data : mem_q[bus.rd_addr2];
  assign bus.busy1     = busy_q[bus.rd_addr1] && !fwd1;
  assign bus.busy2     = busy_q[bus.rd_addr2] && !fwd2;
  assign bus.iss_ready = !busy_q[bus.iss_addr] || fwd_iss;

  // Issue is applied after writeback so a same-address new producer keeps busy set.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_eff) begin
      mem_d[bus.wr_addr]  = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (iss_eff) busy_d[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb; expectations follow RF_ZERO_REG_EN when defined.
module tb_register_file_sb;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  register_file_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  register_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // 1: reset, then every address reads 0, idle, issuable
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr1 = a[2:0]; bus.rd_addr2 = a[2:0]; bus.iss_addr = a[2:0];
      #1;
      chk($sformatf("rst_rd1_%0d", a), 32'(bus.rd_data1), 32'h0);
      chk($sformatf("rst_rd2_%0d", a), 32'(bus.rd_data2), 32'h0);
      chk($sformatf("rst_busy1_%0d", a), 32'(bus.busy1), 32'h0);
      chk($sformatf("rst_busy2_%0d", a), 32'(bus.busy2), 32'h0);
      chk($sformatf("rst_issrdy_%0d", a), 32'(bus.iss_ready), 32'h1);
    end

    // 2: forwarding then storage read
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'hBEEF; bus.rd_addr1 = 3'd3;
    #1 chk("fwd_rd1", 32'(bus.rd_data1), 32'hBEEF);
    @(negedge clk); idle();
    #1 chk("stored_rd1", 32'(bus.rd_data1), 32'hBEEF);

    // 3: issue 5, busy visible next cycle, second issue dropped, writeback clears
    @(negedge clk);
    bus.iss_en = 1'b1; bus.iss_addr = 3'd5; bus.rd_addr2 = 3'd5;
    #1 chk("iss5_ready_pre", 32'(bus.iss_ready), 32'h1);
    chk("iss5_busy2_pre", 32'(bus.busy2), 32'h0);
    @(negedge clk);
    #1 chk("iss5_busy2", 32'(bus.busy2), 32'h1);
    chk("iss5_ready_busy", 32'(bus.iss_ready), 32'h0);
    @(negedge clk); idle();
    bus.iss_addr = 3'd5;
    #1 chk("iss5_busy2_held", 32'(bus.busy2), 32'h1);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'h0042;
    #1 chk("wb5_busy2_fwd", 32'(bus.busy2), 32'h0);
    chk("wb5_rd2_fwd", 32'(bus.rd_data2), 32'h0042);
    chk("wb5_issrdy_fwd", 32'(bus.iss_ready), 32'h1);
    @(negedge clk); idle();
    bus.iss_addr = 3'd5;
    #1 chk("wb5_busy2_after", 32'(bus.busy2), 32'h0);
    chk("wb5_rd2_after", 32'(bus.rd_data2), 32'h0042);
    chk("wb5_issrdy_after", 32'(bus.iss_ready), 32'h1);

    // 4: register 2 busy; same-cycle writeback + reissue leaves data written and busy set
    @(negedge clk);
    bus.iss_en = 1'b1; bus.iss_addr = 3'd2;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h1111;
    #1 chk("wbiss2_ready", 32'(bus.iss_ready), 32'h1);
    @(negedge clk); idle();
    bus.rd_addr1 = 3'd2; bus.iss_addr = 3'd2;
    #1 chk("wbiss2_rd1", 32'(bus.rd_data1), 32'h1111);
    chk("wbiss2_busy1", 32'(bus.busy1), 32'h1);
    chk("wbiss2_issrdy", 32'(bus.iss_ready), 32'h0);

    // different addresses: writeback 4 and issue 1 both take effect
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'h5A5A;
    bus.iss_en = 1'b1; bus.iss_addr = 3'd1;
    @(negedge clk); idle();
    bus.rd_addr1 = 3'd4; bus.rd_addr2 = 3'd1;
    #1 chk("diff_rd1", 32'(bus.rd_data1), 32'h5A5A);
    chk("diff_busy1", 32'(bus.busy1), 32'h0);
    chk("diff_busy2", 32'(bus.busy2), 32'h1);

    // 5: mem[6]=1234 and busy, then reset mid-operation
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'h1234;
    @(negedge clk); idle();
    bus.iss_en = 1'b1; bus.iss_addr = 3'd6;
    @(negedge clk); idle();
    bus.rd_addr1 = 3'd6; bus.iss_addr = 3'd6;
    #1 chk("pre_rst_rd1", 32'(bus.rd_data1), 32'h1234);
    chk("pre_rst_busy1", 32'(bus.busy1), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 16'hAAAA;
    bus.iss_en = 1'b1; bus.iss_addr = 3'd7; bus.rd_addr2 = 3'd7;
    #1 chk("rst_fwd_rd2", 32'(bus.rd_data2), 32'hAAAA);
    @(negedge clk);
    rst = 1'b0; idle();
    bus.iss_addr = 3'd6;
    #1 chk("post_rst_rd1", 32'(bus.rd_data1), 32'h0);
    chk("post_rst_busy1", 32'(bus.busy1), 32'h0);
    chk("post_rst_issrdy6", 32'(bus.iss_ready), 32'h1);
    chk("post_rst_rd2_7", 32'(bus.rd_data2), 32'h0);
    chk("post_rst_busy2_7", 32'(bus.busy2), 32'h0);
    bus.iss_addr = 3'd2;
    #1 chk("post_rst_issrdy2", 32'(bus.iss_ready), 32'h1);

    // 6: register 0 behaviour
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'hFFFF; bus.rd_addr1 = 3'd0;
    #1 chk("r0_fwd_rd1", 32'(bus.rd_data1), ZR ? 32'h0 : 32'hFFFF);
    @(negedge clk); idle();
    bus.iss_en = 1'b1; bus.iss_addr = 3'd0;
    #1 chk("r0_stored_rd1", 32'(bus.rd_data1), ZR ? 32'h0 : 32'hFFFF);
    @(negedge clk); idle();
    bus.iss_addr = 3'd0;
    #1 chk("r0_busy1", 32'(bus.busy1), ZR ? 32'h0 : 32'h1);
    chk("r0_issrdy", 32'(bus.iss_ready), ZR ? 32'h1 : 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
